key_schedule: RTL
=================

# key_schedule

AES key-expansion stage directly upstream of `cipher`. Accepts a 128- or 256-bit cipher key, expands it iteratively (one 32-bit word per cycle) into the full round-key set, and stores it in an internal round-key RAM. Exposes the synchronous read port that `cipher` drives with `round_key_no` and samples on `key`. Replaces the behavioural key SRAM used in cipher benches.

## Interface
- `KEY_BITS`, 256: width of `key_in`; 128-bit keys are MSB-aligned.
- `RAM_DEPTH`, `Nr_256`+1 (15): round-key entries.

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin expansion; sampled only in IDLE.
- `key_len`  in  1  0 = AES-128, 1 = AES-256; sampled with `start`.
- `key_in`  in  256  cipher key; AES-128 uses `key_in[255:128]`.
- `round_key_no`  in  `Nb`  read index from `cipher`.
- `key`  out  `ROUND_KEY_BITS`  registered round key for `round_key_no`.
- `rounds_total`  out  `Nb`  `Nr_128` or `Nr_256` for the stored schedule.
- `busy`  out  1  expansion in progress.
- `done`  out  1  one-cycle pulse when the last round key is written.
- `key_valid`  out  1  RAM holds a complete schedule.

## Operation
- FSM states: IDLE, INIT, EXPAND.
  - IDLE: on `start`, latch `key_len`/`key_in`, set `busy`, clear `key_valid`, then go to INIT.
  - INIT: write rk0 = key words w0..w3 and load the sliding window. AES-256 spends a second INIT cycle writing rk1 = w4..w7. Then go to EXPAND with i = Nk (4 or 8).
  - EXPAND: compute one word per cycle using the FIPS-197 recurrence `w[i] = w[i-Nk] ^ t`, where t = w[i-1] with these substitutions:
    - i%Nk==0: t = SubWord(RotWord(w[i-1])) ^ {Rcon,24'h0}.
    - Nk==8 and i%Nk==4: t = SubWord(w[i-1]).
  - EXPAND: when i%4==3, write the assembled 4-word round key to RAM[i/4].
  - EXPAND exit: after word 4*(Nr+1)-1 (43 or 59), pulse `done`, clear `busy`, set `key_valid`, return to IDLE.
- Sliding window is 8×32-bit shift register; AES-128 uses the newest 4 entries.
- Rcon is a register: reset/start value 8'h01, advanced by xtime (shift left, XOR 8'h1b on carry) after each i%Nk==0 word.
- `start` outside IDLE is ignored. No restart or abort except `reset`.
- `rounds_total` updates at `start` acceptance and holds until the next accepted `start`.
- Read port is free-running every cycle: `key <= RAM[round_key_no]`.
  - Index ≥ `RAM_DEPTH` returns 0.
  - Read and write to the same index on the same edge return old data.
  - Reads while `key_valid`=0 return undefined contents; `cipher` must not be enabled before `key_valid`.

## Timing
- Reset values: `key`=0, `busy`=0, `done`=0, `key_valid`=0, `rounds_total`=`Nr_128`, FSM=IDLE, Rcon=8'h01. RAM contents are not reset.
- `start` accepted at edge E0.
  - AES-128: rk0 written at E1; rk1..rk10 written at E5, E9, …, E41. `done` is high during the cycle after E41, so latency is 41 cycles.
  - AES-256: rk0/rk1 written at E1/E2; rk2..rk14 written at E6, E10, …, E54. Latency is 54 cycles.
- `busy` is high from E0 through the edge of the final write. `key_valid` rises together with `done`.
- Read latency is 1 cycle: `round_key_no` set before edge N gives `key` valid after edge N.
- `reset` asserted mid-expansion: all outputs return to reset values immediately; the partial schedule is discarded (`key_valid` stays 0).

## Structure
- Shared `aes.vh` package: `Nb`, `Nr_128`, `Nr_256`, `BLK_S`, `ROUND_KEY_BITS`, plus new `Nk_128`=4, `Nk_256`=8 and the FSM state enum.
- One sub-module: `sub_word`, a combinational 32-bit SubWord built from four instances of the existing S-box table.
- RAM is inferred as a single-write, single-read synchronous array (BRAM/LUTRAM friendly).

## Test plan
- AES-128 key 000102…0e0f, `start`: `done` exactly 41 cycles later. Reads: rk1=D6AA74FDD2AF72FADAA678F1D6AB76FE, rk10=13111D7FE3944A17F307A78B4D2B30C5, `rounds_total`=10.
- AES-256 key 000102…1e1f, `start`: `done` 54 cycles later. Reads: rk2=A573C29FA176C498A97FCE93A572C09C, rk14=24FC79CCBF0979E9371AC23C6D68DE36, `rounds_total`=14.
- Integrate with `cipher` on plaintext 00112233…eeff: 128-bit gives ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a; then re-key 256-bit gives 8ea2b7ca516745bfeafc49904b496089.
- `start` pulsed at cycle 10 of an AES-128 expansion: ignored. `done` still at cycle 41 and rk10 still correct.
- `reset` low at cycle 20 of an AES-256 expansion: `busy`/`key_valid`/`key` go to 0 asynchronously. A fresh AES-128 run then produces correct keys.
- Read `round_key_no`=15 after AES-256 expansion returns 0. Back-to-back reads 0..14 give one new key per cycle with 1-cycle latency.

Source files
------------

// File: rtl/key_schedule_pkg.sv
// Shared AES parameters, key-schedule FSM states and byte-level helpers.
// Used by the key expansion datapath and its SubWord unit.
package key_schedule_pkg;

    localparam int Nb             = 4;
    localparam int Nr_128         = 10;
    localparam int Nr_256         = 14;
    localparam int Nk_128         = 4;
    localparam int Nk_256         = 8;
    localparam int BLK_S          = 128;
    localparam int ROUND_KEY_BITS = 128;

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        EXPAND
    } ks_state_t;

    // Forward S-box, entry 0 in the top byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] a);
        return SBOX[{~a, 3'b000} +: 8];
    endfunction

    // Multiply by x in GF(2^8); advances Rcon.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/key_schedule_sub_word.sv
// Combinational SubWord: S-box applied to each byte of a 32-bit word.
// Shared by the RotWord and plain-SubWord steps of the expansion.
module key_schedule_sub_word
    import key_schedule_pkg::*;
(
    input  logic [31:0] word_in,
    output logic [31:0] word_out
);

    assign word_out = {
        sbox(word_in[31:24]),
        sbox(word_in[23:16]),
        sbox(word_in[15:8]),
        sbox(word_in[7:0])
    };

endmodule

// File: rtl/key_schedule.sv
// AES-128/256 key expansion, one word per cycle, into a round-key RAM.
// The RAM read port is free-running and feeds the cipher round logic.
module key_schedule
    import key_schedule_pkg::*;
#(
    parameter int KEY_BITS  = 256,
    parameter int RAM_DEPTH = Nr_256 + 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      key_len,
    input  logic [KEY_BITS-1:0]       key_in,
    input  logic [Nb-1:0]             round_key_no,
    output logic [ROUND_KEY_BITS-1:0] key,
    output logic [Nb-1:0]             rounds_total,
    output logic                      busy,
    output logic                      done,
    output logic                      key_valid
);

    ks_state_t             state_q;
    logic [KEY_BITS-1:0]   key_r;
    logic                  len_r;
    logic                  init2;
    logic [5:0]            idx;
    logic [7:0]            rcon;
    logic [7:0][31:0]      win;

    logic [ROUND_KEY_BITS-1:0] ram [RAM_DEPTH];

    logic        at_nk0;
    logic        at_nk4;
    logic [31:0] sw_in;
    logic [31:0] sw_out;
    logic [31:0] t;
    logic [31:0] w_old;
    logic [31:0] w_new;
    logic [5:0]  last_idx;
    logic [255:0] init_win;

    logic                      we;
    logic [Nb-1:0]             waddr;
    logic [ROUND_KEY_BITS-1:0] wdata;

    assign at_nk0   = len_r ? (idx[2:0] == 3'd0) : (idx[1:0] == 2'd0);
    assign at_nk4   = len_r && (idx[2:0] == 3'd4);
    assign sw_in    = at_nk0 ? {win[0][23:0], win[0][31:24]} : win[0];
    assign w_old    = len_r ? win[7] : win[3];
    assign w_new    = w_old ^ t;
    assign last_idx = len_r ? 6'd59 : 6'd43;
    assign init_win = len_r ? key_r[255:0]
                            : {128'h0, key_r[KEY_BITS-1 -: 128]};

    key_schedule_sub_word u_sub_word (
        .word_in  (sw_in),
        .word_out (sw_out)
    );

    // Recurrence temp: rotated/substituted word with Rcon, or pass-through.
    always_comb begin
        t = win[0];
        if (at_nk0) begin
            t = sw_out ^ {rcon, 24'h0};
        end else if (at_nk4) begin
            t = sw_out;
        end
    end

    // RAM write port: key halves in INIT, every fourth word in EXPAND.
    always_comb begin
        we    = 1'b0;
        waddr = '0;
        wdata = '0;
        if (state_q == INIT) begin
            we    = 1'b1;
            waddr = init2 ? Nb'(1) : Nb'(0);
            wdata = init2 ? key_r[KEY_BITS-129 -: 128]
                          : key_r[KEY_BITS-1 -: 128];
        end else if (state_q == EXPAND) begin
            we    = (idx[1:0] == 2'd3);
            waddr = idx[5:2];
            wdata = {win[2], win[1], win[0], w_new};
        end
    end

    // Expansion FSM with its window, word index, Rcon and status flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            key_r        <= '0;
            len_r        <= 1'b0;
            init2        <= 1'b0;
            idx          <= '0;
            rcon         <= 8'h01;
            win          <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            key_valid    <= 1'b0;
            rounds_total <= Nb'(Nr_128);
        end else begin
            done <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        key_r        <= key_in;
                        len_r        <= key_len;
                        init2        <= 1'b0;
                        rcon         <= 8'h01;
                        busy         <= 1'b1;
                        key_valid    <= 1'b0;
                        rounds_total <= key_len ? Nb'(Nr_256)
                                                : Nb'(Nr_128);
                        state_q      <= INIT;
                    end
                end
                INIT: begin
                    win <= init_win;
                    if (len_r && !init2) begin
                        init2 <= 1'b1;
                    end else begin
                        idx     <= len_r ? 6'(Nk_256) : 6'(Nk_128);
                        state_q <= EXPAND;
                    end
                end
                EXPAND: begin
                    win <= {win[6:0], w_new};
                    if (at_nk0) begin
                        rcon <= xtime(rcon);
                    end
                    if (idx == last_idx) begin
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        key_valid <= 1'b1;
                        state_q   <= IDLE;
                    end else begin
                        idx <= idx + 6'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Round-key storage; contents survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            ram[waddr] <= wdata;
        end
    end

    // Free-running registered read; out-of-range index reads zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key <= '0;
        end else if (int'(round_key_no) < RAM_DEPTH) begin
            key <= ram[round_key_no];
        end else begin
            key <= '0;
        end
    end

endmodule
